// File: rtl/muladd_pkg.sv
// Shared types and helpers for the streaming multiply-add unit.
package muladd_pkg;

    typedef enum logic [1:0] {
        MODE_MULADD = 2'd0,
        MODE_MULSUB = 2'd1,
        MODE_ADD3   = 2'd2,
        MODE_MUL    = 2'd3
    } mode_e;

    localparam int RUN_LEN  = 3;
    localparam int PIPE_LAT = 2;

    // Widest signed intermediate: 2*64+2 bits covers every legal W.
    localparam int MAX_IW = 130;

    function automatic logic signed [MAX_IW-1:0] sat_trunc(
        input logic signed [MAX_IW-1:0] value,
        input int                       ow,
        input bit                       sat
    );
        logic signed [MAX_IW-1:0] mask;
        mask = ~({MAX_IW{1'b1}} << ow);
        if (sat && (value < 0)) begin
            sat_trunc = '0;
        end else if (sat && (value > mask)) begin
            sat_trunc = mask;
        end else begin
            sat_trunc = value & mask;
        end
    endfunction

endpackage

// File: rtl/muladd_pipe.sv
// Two-stage arithmetic pipe: stage 1 forms a*b (or a+b), stage 2 applies c and the output range rule.
module muladd_pipe
    import muladd_pkg::*;
#(
    parameter int W   = 32,
    parameter int OW  = 32,
    parameter int SAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_valid,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic [W-1:0]  i_c,
    input  mode_e         i_mode,
    output logic          o_valid,
    output logic [OW-1:0] o_data,
    output logic          o_range_evt,
    output logic          o_load
);
    localparam int IW = 2*W + 2;

    logic signed [IW-1:0]     r_p1;
    logic [W-1:0]             r_c1;
    mode_e                    r_mode1;
    logic                     r_v1;
    logic                     r_v2;
    logic [OW-1:0]            r_data;

    logic signed [IW-1:0]     w_a;
    logic signed [IW-1:0]     w_b;
    logic signed [IW-1:0]     w_c;
    logic signed [IW-1:0]     w_p;
    logic signed [IW-1:0]     w_res;
    logic signed [MAX_IW-1:0] w_ext;
    logic signed [MAX_IW-1:0] w_st;

    assign w_a = $signed({{(W+2){1'b0}}, i_a});
    assign w_b = $signed({{(W+2){1'b0}}, i_b});
    assign w_c = $signed({{(W+2){1'b0}}, r_c1});
    assign w_p = (i_mode == MODE_ADD3) ? (w_a + w_b) : (w_a * w_b);

    always_comb begin
        w_res = r_p1 + w_c;
        case (r_mode1)
            MODE_MULSUB: w_res = r_p1 - w_c;
            MODE_MUL:    w_res = r_p1;
            default:     w_res = r_p1 + w_c;
        endcase
    end

    // A result is in range exactly when the range rule leaves it untouched.
    assign w_ext       = MAX_IW'(w_res);
    assign w_st        = sat_trunc(w_ext, OW, SAT != 0);
    assign o_range_evt = r_v1 && (w_st != w_ext);
    assign o_load      = r_v1 && !i_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_p1    <= '0;
            r_c1    <= '0;
            r_mode1 <= MODE_MULADD;
            r_data  <= '0;
        end else if (i_clr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) begin
                r_p1    <= w_p;
                r_c1    <= i_c;
                r_mode1 <= i_mode;
            end
            if (r_v1) begin
                r_data <= w_st[OW-1:0];
            end
        end
    end

    assign o_valid = r_v2;
    assign o_data  = r_data;

endmodule

// File: rtl/muladd_stream.sv
// Streaming op(a,b,c) over a sliding window of three consecutive valid samples.
// valido is a one-cycle strobe per result with no backpressure; data_out holds the last result.
module muladd_stream
    import muladd_pkg::*;
#(
    parameter int W     = 32,
    parameter int OW    = 32,
    parameter int SAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             validi,
    input  logic [W-1:0]     data_in,
    input  logic [1:0]       mode,
    output logic             valido,
    output logic [OW-1:0]    data_out,
    output logic             ovf,
    output logic [CNT_W-1:0] res_cnt
);
    logic [1:0]       r_run;
    logic [W-1:0]     r_win_a;
    logic [W-1:0]     r_win_b;
    logic [W-1:0]     r_win_c;
    mode_e            r_mode;
    logic             r_fire;
    logic             r_ovf;
    logic [CNT_W-1:0] r_res_cnt;

    logic             w_fire;
    logic             w_range_evt;
    logic             w_load;

    assign w_fire = validi && (r_run >= 2'(RUN_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= '0;
            r_win_a <= '0;
            r_win_b <= '0;
            r_win_c <= '0;
            r_mode  <= MODE_MULADD;
            r_fire  <= 1'b0;
        end else if (clr) begin
            r_run   <= '0;
            r_win_a <= '0;
            r_win_b <= '0;
            r_win_c <= '0;
            r_fire  <= 1'b0;
        end else begin
            r_fire <= w_fire;
            if (validi) begin
                r_run   <= (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;
                r_win_a <= r_win_b;
                r_win_b <= r_win_c;
                r_win_c <= data_in;
                r_mode  <= mode_e'(mode);
            end else begin
                r_run <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_res_cnt <= '0;
        end else if (clr) begin
            r_ovf     <= 1'b0;
            r_res_cnt <= '0;
        end else begin
            if (w_range_evt) begin
                r_ovf <= 1'b1;
            end
            if (w_load) begin
                r_res_cnt <= r_res_cnt + 1'b1;
            end
        end
    end

    muladd_pipe #(
        .W   (W),
        .OW  (OW),
        .SAT (SAT)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clr),
        .i_valid     (r_fire),
        .i_a         (r_win_a),
        .i_b         (r_win_b),
        .i_c         (r_win_c),
        .i_mode      (r_mode),
        .o_valid     (valido),
        .o_data      (data_out),
        .o_range_evt (w_range_evt),
        .o_load      (w_load)
    );

    assign ovf     = r_ovf;
    assign res_cnt = r_res_cnt;

endmodule

// File: doc/muladd_stream.md
Name: muladd_stream

Overview:
- Parametrised streaming multiply-add unit; next generation of the fixed 32-bit a*b+c block.
- Watches a qualified input stream. Once three consecutive valid samples a (oldest), b and c are present, it emits op(a,b,c) after a fixed 2-cycle pipeline.
- Adds: configurable width, run-time operation mode, optional saturation, sticky overflow flag, synchronous clear and a result counter.
- Sits between the sample source and the result consumer in the lab datapath.

Parameters:
- W, 32, input sample width (unsigned), legal 4..64
- OW, 32, output width; result truncated or saturated to OW bits, legal 4..2*W+1
- SAT, 0, 0 = wrap (keep low OW bits), 1 = clamp to 2**OW-1 on overflow and 0 on underflow
- CNT_W, 16, width of the result counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear; higher priority than all other inputs
- validi  in  1  data_in qualifier
- data_in  in  W  sample
- mode  in  2  operation, sampled with c (see Behaviour)
- valido  out  1  data_out valid, single-cycle per result
- data_out  out  OW  result
- ovf  out  1  sticky overflow/underflow flag
- res_cnt  out  CNT_W  number of results emitted, wraps

Behaviour:
- Reset (rst_n=0, async): valido=0, data_out=0, ovf=0, res_cnt=0, run counter=0, sample window and pipeline valid bits cleared.
- Run counter: saturating 2-bit counter.
  - Increments on each edge where validi=1.
  - Goes to 0 on any edge where validi=0.
  - The window shifts only when validi=1: a<=b, b<=c, c<=data_in.
- Fire: at edge k, if validi=1 and the run counter is already >=2, the triple is (sample k-2, k-1, k).
  - The triple and mode go into pipeline stage 1.
  - Consecutive validi gives a sliding window, one result per cycle.
- Modes: 0 a*b+c, 1 a*b-c, 2 a+b+c, 3 a*b.
  - Compute in 2*W+2 bit signed intermediate.
- Latency:
  - Stage 1 registers the product (or a+b for mode 2).
  - Stage 2 registers the final add/sub and range check.
  - valido rises at edge k+2 for a fire at edge k; data_out holds its value until the next result (not cleared when valido=0).
- Range handling:
  - A result <0 or >2**OW-1 sets ovf, which stays set until clr or reset.
  - SAT=0: data_out = low OW bits.
  - SAT=1: data_out is clamped.
- Gap: validi=0 drops the run counter, but in-flight results still emerge. Three new consecutive samples are needed before the next fire; the old window is never reused.
- res_cnt increments on every cycle valido=1; wraps at 2**CNT_W.
- clr=1 at an edge:
  - Clears run counter, window, both pipeline valids, ovf and res_cnt; valido=0 next cycle. data_out is unchanged.
  - validi in the same cycle is ignored.
- Reset mid-stream: all in-flight results are discarded; no valido until 3 fresh samples plus 2 cycles.
- mode changing mid-run applies per result, sampled at the fire edge.

Decomposition:
- Package muladd_pkg:
  - mode_e enum (MODE_MULADD, MODE_MULSUB, MODE_ADD3, MODE_MUL)
  - localparams RUN_LEN=3, PIPE_LAT=2
  - function sat_trunc(value, OW, SAT)
- One sub-module, muladd_pipe: the 2-stage arithmetic pipe with valid bits.
- muladd_stream holds the run counter, window, ovf, res_cnt and clr/reset control.

Test Plan:
- Mode 0, defaults; validi=1 for 3 cycles with 2,3,4 -> valido one cycle, 2 edges after the 3rd sample, data_out=10, res_cnt=1, ovf=0.
- Mode 0; validi=1 continuously with 1,2,3,4,5 -> three results on consecutive cycles: 5, 10, 17; then valido=0.
- Mode 0; 2 samples, 1 idle cycle, then 3 samples 1,1,1 -> no result from the broken run; single result 2.
- Mode 1, SAT=0, OW=8, W=8; samples 0,5,1 -> ovf=1, data_out=8'hFF. Same stimulus with SAT=1 -> data_out=0, ovf=1.
- Mode 0, W=8, OW=8, SAT=1; samples 255,255,0 -> data_out=255, ovf=1. Then clr pulse -> ovf=0, res_cnt=0.
- Fire then rst_n low for 1 cycle before valido -> no valido, all outputs 0. Fire then clr the next cycle -> no valido, data_out retains its previous value.
